// File: rtl/fir_window_queue.sv
// Sliding-window sample queue: decimates incoming samples into a ring buffer and,
// once a full window is held, replays the newest WIN samples (oldest first) per store.
module fir_window_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned WIN    = 1021,
  parameter int unsigned DECIM  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] new_smpl_i,
  input  logic                     valid_rise_i,
  input  logic                     flush_i,
  output logic signed [DATA_W-1:0] smpl_out_o,
  output logic                     smpl_vld_o,
  output logic                     sequencing_o,
  output logic                     seq_done_o,
  output logic                     full_o,
  output logic                     overrun_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(WIN + 1);
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [DW-1:0] DecMax = DW'(DECIM - 1);
  localparam logic [CW-1:0] WinCnt = CW'(WIN);
  localparam logic [CW-1:0] LastCnt = CW'(WIN - 1);
  localparam logic [AW-1:0] WinOff = AW'(WIN);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  logic signed [DATA_W-1:0] ram_q [DEPTH];

  state_e         state_q, state_d;
  logic [DW-1:0]  dec_cnt_q, dec_cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           pend_q, pend_d;
  logic [AW-1:0]  pend_start_q, pend_start_d;
  logic           overrun_q, overrun_d;
  logic           vld_q, vld_d;
  logic           done_q, done_d;
  logic signed [DATA_W-1:0] rd_data_q;

  logic          store;
  logic          req;
  logic          last;
  logic          rd_en;
  logic [AW-1:0] req_start;

  // Next-state for decimation, write side, occupancy and the burst sequencer.
  always_comb begin
    store     = valid_rise_i && (dec_cnt_q == DecMax);
    dec_cnt_d = dec_cnt_q;
    if (valid_rise_i) begin
      dec_cnt_d = (dec_cnt_q == DecMax) ? '0 : dec_cnt_q + DW'(1);
    end
    wr_ptr_d  = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d     = (store && (cnt_q != WinCnt)) ? cnt_q + CW'(1) : cnt_q;
    // Any store that leaves the window full asks for a burst.
    req       = store && (cnt_d == WinCnt);
    req_start = wr_ptr_d - WinOff;
    last      = (state_q == StBurst) && (rd_cnt_q == LastCnt);

    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    rd_cnt_d     = rd_cnt_q;
    pend_d       = pend_q;
    pend_start_d = pend_start_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StBurst;
          rd_ptr_d = req_start;
          rd_cnt_d = '0;
        end
      end
      StBurst: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rd_cnt_d = rd_cnt_q + CW'(1);
        // Only one burst can wait; a second waiting request is dropped.
        if (req) begin
          if (pend_q) begin
            overrun_d = 1'b1;
          end else if (!last) begin
            pend_d       = 1'b1;
            pend_start_d = req_start;
          end
        end
        if (last) begin
          rd_cnt_d = '0;
          if (pend_q) begin
            rd_ptr_d = pend_start_q;
            pend_d   = 1'b0;
          end else if (req) begin
            // Request on the last address chains straight into the next burst.
            rd_ptr_d = req_start;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    vld_d  = (state_q == StBurst);
    done_d = last;

    // Flush wins over everything, including a coincident strobe.
    if (flush_i) begin
      state_d      = StIdle;
      dec_cnt_d    = '0;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      rd_ptr_d     = '0;
      rd_cnt_d     = '0;
      pend_d       = 1'b0;
      pend_start_d = '0;
      overrun_d    = 1'b0;
      vld_d        = 1'b0;
      done_d       = 1'b0;
    end
  end

  assign rd_en = (state_q == StBurst) && !flush_i;

  // Sample storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (store && !flush_i) begin
      ram_q[wr_ptr_q] <= new_smpl_i;
    end
  end

  // Registered read port; forced to zero outside a burst so the output is 0 when not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_en ? ram_q[rd_ptr_q] : '0;
    end
  end

  // State, pointers, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dec_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      pend_q       <= 1'b0;
      pend_start_q <= '0;
      overrun_q    <= 1'b0;
      vld_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_cnt_q    <= dec_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      pend_q       <= pend_d;
      pend_start_q <= pend_start_d;
      overrun_q    <= overrun_d;
      vld_q        <= vld_d;
      done_q       <= done_d;
    end
  end

  assign smpl_out_o   = rd_data_q;
  assign smpl_vld_o   = vld_q;
  assign sequencing_o = (state_q == StBurst);
  assign seq_done_o   = done_q;
  assign full_o       = (cnt_q == WinCnt);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_fir_window_queue.sv
// Directed bench for fir_window_queue: a DEPTH=16/WIN=8/DECIM=2 instance and a
// DEPTH=16/WIN=15/DECIM=1 instance, sample value = strobe index.
module tb_fir_window_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Instance A
  logic signed [15:0] a_new;
  logic               a_valid;
  logic               a_flush;
  logic signed [15:0] a_out;
  logic               a_vld, a_seq, a_done, a_full, a_ovr;

  // Instance B
  logic signed [15:0] b_new;
  logic               b_valid;
  logic               b_flush;
  logic signed [15:0] b_out;
  logic               b_vld, b_seq, b_done, b_full, b_ovr;

  fir_window_queue #(.DATA_W(16), .DEPTH(16), .WIN(8), .DECIM(2)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_smpl_i   (a_new),
    .valid_rise_i (a_valid),
    .flush_i      (a_flush),
    .smpl_out_o   (a_out),
    .smpl_vld_o   (a_vld),
    .sequencing_o (a_seq),
    .seq_done_o   (a_done),
    .full_o       (a_full),
    .overrun_o    (a_ovr)
  );

  fir_window_queue #(.DATA_W(16), .DEPTH(16), .WIN(15), .DECIM(1)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_smpl_i   (b_new),
    .valid_rise_i (b_valid),
    .flush_i      (b_flush),
    .smpl_out_o   (b_out),
    .smpl_vld_o   (b_vld),
    .sequencing_o (b_seq),
    .seq_done_o   (b_done),
    .full_o       (b_full),
    .overrun_o    (b_ovr)
  );

  // Output capture, sampled on the falling edge.
  logic signed [15:0] a_vals[$];
  int                 a_cyc[$];
  int                 a_done_cyc[$];
  int                 a_seq_cnt = 0;
  int                 a_zero_viol = 0;
  logic signed [15:0] b_vals[$];
  int                 b_zero_viol = 0;

  always @(negedge clk) begin
    if (a_vld) begin
      a_vals.push_back(a_out);
      a_cyc.push_back(cyc);
    end else if (a_out !== 16'sd0) begin
      a_zero_viol++;
    end
    if (a_done) a_done_cyc.push_back(cyc);
    if (a_seq) a_seq_cnt++;
    if (b_vld) b_vals.push_back(b_out);
    else if (b_out !== 16'sd0) b_zero_viol++;
  end

  task automatic clear_mon();
    a_vals.delete();
    a_cyc.delete();
    a_done_cyc.delete();
    a_seq_cnt = 0;
    b_vals.delete();
  endtask

  // All drive tasks start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int a_last_strobe;

  task automatic strobe_a(input int k);
    a_valid = 1'b1;
    a_new   = 16'(k);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_last_strobe = cyc;
  endtask

  task automatic strobe_b(input int k);
    b_valid = 1'b1;
    b_new   = 16'(k);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic fill_a(input int first, input int last, input int gap);
    for (int k = first; k <= last; k++) begin
      strobe_a(k);
      if (k != last) idle(gap - 1);
    end
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    a_flush = 1'b0;
    b_valid = 1'b0;
    b_flush = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic test_reset();
    a_valid = 1'b0;
    a_flush = 1'b0;
    a_new   = '0;
    b_valid = 1'b0;
    b_flush = 1'b0;
    b_new   = '0;
    #1;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({a_vld, a_seq, a_done, a_full, a_ovr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags_a: got %b expected 00000", {a_vld, a_seq, a_done, a_full, a_ovr});
    end
    n_cmp++;
    if (a_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_out_a: got %0d expected 0", a_out);
    end
    n_cmp++;
    if ({b_vld, b_seq, b_done, b_full, b_ovr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags_b: got %b expected 00000", {b_vld, b_seq, b_done, b_full, b_ovr});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic test_fill();
    int s;
    fill_a(1, 15, 12);
    idle(11);
    n_cmp++;
    if (a_vals.size() != 0 || a_full !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_early: got %0d samples full=%b expected 0 samples full=0",
               a_vals.size(), a_full);
    end
    clear_mon();
    strobe_a(16);
    s = a_last_strobe;
    idle(12);
    n_cmp++;
    if (a_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: got %b expected 1", a_full);
    end
    n_cmp++;
    if (a_vals.size() != 8) begin
      n_fail++;
      $display("FAIL fill_count: got %0d expected 8", a_vals.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (a_vals[i] !== 16'(2 * i + 2) || a_cyc[i] != s + 1 + i) begin
          n_fail++;
          $display("FAIL fill_sample[%0d]: got %0d at cycle %0d expected %0d at cycle %0d",
                   i, a_vals[i], a_cyc[i], 2 * i + 2, s + 1 + i);
        end
      end
    end
    n_cmp++;
    if (a_done_cyc.size() != 1 || a_done_cyc[0] != s + 8) begin
      n_fail++;
      $display("FAIL fill_done: got %0d pulses (first at %0d) expected 1 at %0d",
               a_done_cyc.size(), (a_done_cyc.size() > 0) ? a_done_cyc[0] : -1, s + 8);
    end
    n_cmp++;
    if (a_seq_cnt != 8) begin
      n_fail++;
      $display("FAIL fill_sequencing: got %0d cycles expected 8", a_seq_cnt);
    end
  endtask

  task automatic test_slide();
    for (int k = 17; k <= 40; k++) begin
      clear_mon();
      strobe_a(k);
      idle(11);
      if (k % 2 == 0) begin
        n_cmp++;
        if (a_vals.size() != 8) begin
          n_fail++;
          $display("FAIL slide_count_%0d: got %0d expected 8", k, a_vals.size());
        end else begin
          for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (a_vals[i] !== 16'(k - 14 + 2 * i)) begin
              n_fail++;
              $display("FAIL slide_%0d[%0d]: got %0d expected %0d", k, i, a_vals[i], k - 14 + 2 * i);
            end
          end
        end
      end else begin
        n_cmp++;
        if (a_vals.size() != 0) begin
          n_fail++;
          $display("FAIL slide_odd_%0d: got %0d samples expected 0", k, a_vals.size());
        end
      end
    end
  endtask

  task automatic test_pending(input bit third);
    int exp_v;
    do_reset();
    fill_a(1, 16, 12);
    idle(12);
    clear_mon();
    strobe_a(17);
    strobe_a(18);
    idle(1);
    strobe_a(19);
    strobe_a(20);
    if (third) begin
      strobe_a(21);
      strobe_a(22);
    end
    idle(30);
    n_cmp++;
    if (a_vals.size() != 16) begin
      n_fail++;
      $display("FAIL pend%0d_count: got %0d expected 16", third, a_vals.size());
    end else begin
      n_cmp++;
      if (a_cyc[15] - a_cyc[0] != 15) begin
        n_fail++;
        $display("FAIL pend%0d_gapless: got span %0d expected 15", third, a_cyc[15] - a_cyc[0]);
      end
      for (int i = 0; i < 16; i++) begin
        exp_v = (i < 8) ? 4 + 2 * i : 6 + 2 * (i - 8);
        n_cmp++;
        if (a_vals[i] !== 16'(exp_v)) begin
          n_fail++;
          $display("FAIL pend%0d[%0d]: got %0d expected %0d", third, i, a_vals[i], exp_v);
        end
      end
    end
    n_cmp++;
    if (a_ovr !== third) begin
      n_fail++;
      $display("FAIL pend%0d_overrun: got %b expected %b", third, a_ovr, third);
    end
    n_cmp++;
    if (a_done_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL pend%0d_done: got %0d pulses expected 2", third, a_done_cyc.size());
    end
  endtask

  task automatic test_decim1();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      strobe_b(k);
      idle(19);
    end
    n_cmp++;
    if (b_vals.size() != 0 || b_full !== 1'b0) begin
      n_fail++;
      $display("FAIL decim1_early: got %0d samples full=%b expected 0 samples full=0",
               b_vals.size(), b_full);
    end
    for (int k = 15; k <= 16; k++) begin
      clear_mon();
      strobe_b(k);
      idle(19);
      n_cmp++;
      if (b_vals.size() != 15 || b_full !== 1'b1) begin
        n_fail++;
        $display("FAIL decim1_count_%0d: got %0d samples full=%b expected 15 full=1",
                 k, b_vals.size(), b_full);
      end else begin
        for (int i = 0; i < 15; i++) begin
          n_cmp++;
          if (b_vals[i] !== 16'(k - 14 + i)) begin
            n_fail++;
            $display("FAIL decim1_%0d[%0d]: got %0d expected %0d", k, i, b_vals[i], k - 14 + i);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill_a(1, 16, 12);
    idle(12);
    strobe_a(17);
    strobe_a(18);
    idle(1);
    strobe_a(19);
    strobe_a(20);
    strobe_a(21);
    strobe_a(22);
    idle(1);
    n_cmp++;
    if (a_ovr !== 1'b1 || a_seq !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: got overrun=%b sequencing=%b expected 1 1", a_ovr, a_seq);
    end
    a_flush = 1'b1;
    a_valid = 1'b1;
    a_new   = 16'sd99;
    @(posedge clk);
    #1;
    a_flush = 1'b0;
    a_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_vld, a_seq, a_done, a_full, a_ovr} !== 5'b0 || a_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL flush_clear: got vld/seq/done/full/ovr=%b out=%0d expected 00000 out=0",
               {a_vld, a_seq, a_done, a_full, a_ovr}, a_out);
    end
    @(posedge clk);
    #1;
    clear_mon();
    fill_a(101, 115, 12);
    idle(11);
    n_cmp++;
    if (a_vals.size() != 0 || a_full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_refill_early: got %0d samples full=%b expected 0 samples full=0",
               a_vals.size(), a_full);
    end
    strobe_a(116);
    idle(12);
    n_cmp++;
    if (a_vals.size() != 8) begin
      n_fail++;
      $display("FAIL flush_refill_count: got %0d expected 8", a_vals.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (a_vals[i] !== 16'(102 + 2 * i)) begin
          n_fail++;
          $display("FAIL flush_refill[%0d]: got %0d expected %0d", i, a_vals[i], 102 + 2 * i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_a(1, 16, 12);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_vld, a_seq, a_done, a_full, a_ovr} !== 5'b0 || a_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_mid: got vld/seq/done/full/ovr=%b out=%0d expected 00000 out=0",
               {a_vld, a_seq, a_done, a_full, a_ovr}, a_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    fill_a(201, 216, 12);
    idle(12);
    n_cmp++;
    if (a_vals.size() != 8 || a_full !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_refill_count: got %0d samples full=%b expected 8 full=1",
               a_vals.size(), a_full);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (a_vals[i] !== 16'(202 + 2 * i)) begin
          n_fail++;
          $display("FAIL reset_refill[%0d]: got %0d expected %0d", i, a_vals[i], 202 + 2 * i);
        end
      end
    end
  endtask

  task automatic test_zero_when_invalid();
    n_cmp++;
    if (a_zero_viol != 0 || b_zero_viol != 0) begin
      n_fail++;
      $display("FAIL zero_when_invalid: got %0d/%0d nonzero idle samples expected 0/0",
               a_zero_viol, b_zero_viol);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_pending(1'b0);
    test_pending(1'b1);
    test_decim1();
    test_flush();
    test_reset_mid();
    test_zero_when_invalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
